// File: rtl/iob_cache_req_bridge_if.sv
// Request/response stream, IOb native master and cache side-band signals of iob_cache_req_bridge.
// The bridge uses the slave modport; the requester/cache environment uses master.
interface iob_cache_req_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 8
);
  localparam int NBYTES_W   = $clog2(DATA_W / 8);
  localparam int IOB_ADDR_W = ADDR_W - NBYTES_W;

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [1:0]            req_cmd_i;
  logic [ADDR_W-1:0]     req_addr_i;
  logic [DATA_W-1:0]     req_wdata_i;
  logic [DATA_W/8-1:0]   req_wstrb_i;
  logic [ID_W-1:0]       req_id_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [ID_W-1:0]       rsp_id_o;
  logic [DATA_W-1:0]     rsp_data_o;
  logic                  rsp_sync_o;
  logic                  iob_avalid_o;
  logic [IOB_ADDR_W-1:0] iob_addr_o;
  logic [DATA_W-1:0]     iob_wdata_o;
  logic [DATA_W/8-1:0]   iob_wstrb_o;
  logic                  iob_ready_i;
  logic                  iob_rvalid_i;
  logic [DATA_W-1:0]     iob_rdata_i;
  logic                  invalidate_o;
  logic                  wtb_empty_i;
  logic                  err_o;

  modport slave (
    input  req_valid_i, req_cmd_i, req_addr_i, req_wdata_i, req_wstrb_i, req_id_i,
    input  rsp_ready_i, iob_ready_i, iob_rvalid_i, iob_rdata_i, wtb_empty_i,
    output req_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o, rsp_sync_o,
    output iob_avalid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o, invalidate_o, err_o
  );

  modport master (
    output req_valid_i, req_cmd_i, req_addr_i, req_wdata_i, req_wstrb_i, req_id_i,
    output rsp_ready_i, iob_ready_i, iob_rvalid_i, iob_rdata_i, wtb_empty_i,
    input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o, rsp_sync_o,
    input  iob_avalid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o, invalidate_o, err_o
  );
endinterface

// File: rtl/iob_cache_req_bridge.sv
// Adapts a valid/ready read/write/fence/invalidate stream onto the iob_cache_axi IOb slave port,
// tagging read data with requester IDs and ordering fence/invalidate completions behind reads.
module iob_cache_req_bridge #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ID_W        = 8,
  parameter int RSP_DEPTH_W = 2
) (
  input logic                   clk_i,
  input logic                   cke_i,
  input logic                   arst_i,
  iob_cache_req_bridge_if.slave bus
);
  localparam int NBYTES_W = $clog2(DATA_W / 8);
  localparam int DEPTH    = 2 ** RSP_DEPTH_W;
  localparam logic [RSP_DEPTH_W:0]   CNT_ONE    = (RSP_DEPTH_W + 1)'(1);
  localparam logic [RSP_DEPTH_W:0]   CNT_FULL   = (RSP_DEPTH_W + 1)'(DEPTH);
  localparam logic [RSP_DEPTH_W+1:0] CREDIT_LIM = (RSP_DEPTH_W + 2)'(DEPTH);
  localparam logic [RSP_DEPTH_W-1:0] PTR_ONE    = (RSP_DEPTH_W)'(1);

  typedef enum logic [1:0] {CMD_RD, CMD_WR, CMD_FENCE, CMD_INV} cmd_t;
  typedef enum logic [1:0] {RUN, DRAIN, INVAL, SYNC} state_t;

  state_t state, state_nxt;
  cmd_t   cmd;

  logic [RSP_DEPTH_W:0]   rd_inflight, rsp_count;
  logic [RSP_DEPTH_W-1:0] tag_wr_ptr, tag_rd_ptr, rsp_wr_ptr, rsp_rd_ptr;
  logic [ID_W-1:0]        tag_mem      [DEPTH];
  logic [ID_W-1:0]        rsp_id_mem   [DEPTH];
  logic [DATA_W-1:0]      rsp_data_mem [DEPTH];
  logic                   rsp_sync_mem [DEPTH];
  logic [ID_W-1:0]        sync_id;
  logic                   sync_inv, inv_q, err_q;
  logic                   credit_ok, rd_accept, rd_return, spurious, sync_accept, sync_push;
  logic                   rsp_push, rsp_pop, rsp_valid, rsp_full;
  logic [ID_W-1:0]        push_id;
  logic [DATA_W-1:0]      push_data;
  logic                   unused_addr_lsb;

  assign cmd             = cmd_t'(bus.req_cmd_i);
  assign unused_addr_lsb = ^bus.req_addr_i[NBYTES_W-1:0];
  assign credit_ok       = ({1'b0, rd_inflight} + {1'b0, rsp_count}) < CREDIT_LIM;
  assign rsp_valid       = (rsp_count != '0);
  assign rsp_full        = (rsp_count == CNT_FULL);

  assign rd_accept   = bus.req_valid_i & bus.req_ready_o & (cmd == CMD_RD);
  assign sync_accept = bus.req_valid_i & bus.req_ready_o & cmd[1];
  assign rd_return   = cke_i & bus.iob_rvalid_i & (rd_inflight != '0);
  assign spurious    = cke_i & bus.iob_rvalid_i & (rd_inflight == '0);
  assign rsp_push    = rd_return | sync_push;
  assign rsp_pop     = cke_i & rsp_valid & bus.rsp_ready_i;
  // SYNC is only reachable with no reads in flight, so both push sources are exclusive
  assign push_id     = rd_return ? tag_mem[tag_rd_ptr] : sync_id;
  assign push_data   = rd_return ? bus.iob_rdata_i : '0;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state <= RUN;
    else if (cke_i) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (sync_accept) state_nxt = DRAIN;
      DRAIN:   if ((rd_inflight == '0) && bus.wtb_empty_i) state_nxt = sync_inv ? INVAL : SYNC;
      INVAL:   state_nxt = SYNC;
      SYNC:    if (sync_push) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    bus.req_ready_o  = 1'b0;
    bus.iob_avalid_o = 1'b0;
    bus.iob_wstrb_o  = '0;
    sync_push        = 1'b0;
    if ((state == RUN) && (cmd == CMD_WR)) bus.iob_wstrb_o = bus.req_wstrb_i;
    if (cke_i) begin
      unique case (state)
        RUN: begin
          unique case (cmd)
            CMD_RD: begin
              bus.iob_avalid_o = bus.req_valid_i & credit_ok;
              bus.req_ready_o  = bus.iob_avalid_o & bus.iob_ready_i;
            end
            CMD_WR: begin
              bus.iob_avalid_o = bus.req_valid_i;
              bus.req_ready_o  = bus.iob_ready_i;
            end
            default: bus.req_ready_o = 1'b1;
          endcase
        end
        SYNC:    sync_push = ~rsp_full;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rd_inflight <= '0;
      rsp_count   <= '0;
      tag_wr_ptr  <= '0;
      tag_rd_ptr  <= '0;
      rsp_wr_ptr  <= '0;
      rsp_rd_ptr  <= '0;
      sync_id     <= '0;
      sync_inv    <= 1'b0;
      inv_q       <= 1'b0;
      err_q       <= 1'b0;
    end else if (cke_i) begin
      if (rd_accept && !rd_return) rd_inflight <= rd_inflight + CNT_ONE;
      else if (!rd_accept && rd_return) rd_inflight <= rd_inflight - CNT_ONE;
      if (rsp_push && !rsp_pop) rsp_count <= rsp_count + CNT_ONE;
      else if (!rsp_push && rsp_pop) rsp_count <= rsp_count - CNT_ONE;
      if (rd_accept) tag_wr_ptr <= tag_wr_ptr + PTR_ONE;
      if (rd_return) tag_rd_ptr <= tag_rd_ptr + PTR_ONE;
      if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + PTR_ONE;
      if (rsp_pop) rsp_rd_ptr <= rsp_rd_ptr + PTR_ONE;
      if (sync_accept) begin
        sync_id  <= bus.req_id_i;
        sync_inv <= cmd[0];
      end
      inv_q <= (state_nxt == INVAL);
      if (spurious) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rd_accept) tag_mem[tag_wr_ptr] <= bus.req_id_i;
    if (rsp_push) begin
      rsp_id_mem[rsp_wr_ptr]   <= push_id;
      rsp_data_mem[rsp_wr_ptr] <= push_data;
      rsp_sync_mem[rsp_wr_ptr] <= sync_push;
    end
  end

  assign bus.rsp_valid_o  = rsp_valid;
  assign bus.rsp_id_o     = rsp_valid ? rsp_id_mem[rsp_rd_ptr] : '0;
  assign bus.rsp_data_o   = rsp_valid ? rsp_data_mem[rsp_rd_ptr] : '0;
  assign bus.rsp_sync_o   = rsp_valid & rsp_sync_mem[rsp_rd_ptr];
  assign bus.iob_addr_o   = bus.req_addr_i[ADDR_W-1:NBYTES_W];
  assign bus.iob_wdata_o  = bus.req_wdata_i;
  assign bus.invalidate_o = inv_q;
  assign bus.err_o        = err_q;
endmodule
